axi_wr_slave: RTL and testbench

AXI_WR_SLAVE -- requirements
Module: axi_wr_slave

---
 rtl/axi_pkg.sv | 46 ++++
 rtl/axi_wr_slave.sv | 240 ++++++++++++++++++++++++
 tb/tb_axi_wr_slave.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg
// Shared AXI definitions for the write-slave slice.
//   ID_W      : fixed AXI ID width (4 bits)
//   resp_t    : B-channel response codes (OKAY, SLVERR and the rest)
//   burst_t   : AW burst-type codes
//   state_t   : one-hot state encodings of the write slave
//   isAligned : true when the low address bits are aligned to 2^size
// ---------------------------------------------------------------------------
package axi_pkg;

    localparam int ID_W = 4;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_t;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_DRAIN = 4'b0010,
        ST_WRITE = 4'b0100,
        ST_RESP  = 4'b1000
    } state_t;

    // Sizes above one 32-bit word are never aligned (they are illegal anyway).
    function automatic logic isAligned(input logic [1:0] addrLo, input logic [2:0] size);
        logic ok;
        case (size)
            3'd0:    ok = 1'b1;
            3'd1:    ok = ~addrLo[0];
            3'd2:    ok = (addrLo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/axi_wr_slave.sv
// ---------------------------------------------------------------------------
// axi_wr_slave
// Single-beat AXI write slave in front of an external word-addressed memory.
// Accepts one AW and one W beat (in either order or together), performs a
// single one-cycle memory write when the access is legal, and answers on B.
// Bursts (awlen != 0) are drained and answered with SLVERR.
//
// Ports
//   clk, resetn                     : clock (rising edge), async active-low reset
//   awid/awaddr/awlen/awsize/awburst: AW channel payload, awvalid/awready handshake
//   wid/wdata/wstrb/wlast           : W channel payload, wvalid/wready handshake
//   bid/bresp                       : B channel payload, bvalid/bready handshake
//   mem_en/mem_we/mem_addr/mem_wdata: write port of the external memory
//
// Configuration
//   AXI_WR_ALIGN_CHECK_EN : when defined, an awaddr misaligned to 2^awsize
//                           makes the access illegal (SLVERR, no write).
// ---------------------------------------------------------------------------
module axi_wr_slave
    import axi_pkg::*;
#(
    parameter int MEM_AW = 10
)
(
    input  logic              clk,
    input  logic              resetn,

    input  logic [ID_W-1:0]   awid,
    input  logic [31:0]       awaddr,
    input  logic [7:0]        awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic              awvalid,
    output logic              awready,

    input  logic [ID_W-1:0]   wid,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,

    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,

    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata
);

    state_t              r_state;
    logic                r_awready;
    logic                r_wready;
    logic                r_awCap;
    logic                r_wCap;
    logic [ID_W-1:0]     r_awid;
    logic [MEM_AW+1:0]   r_awaddr;
    logic [7:0]          r_awlen;
    logic [2:0]          r_awsize;
    logic [ID_W-1:0]     r_wid;
    logic [31:0]         r_wdata;
    logic [3:0]          r_wstrb;
    logic                r_wlast;
    logic                r_bvalid;
    logic [ID_W-1:0]     r_bid;
    logic [1:0]          r_bresp;
    logic                r_memEn;
    logic [3:0]          r_memWe;
    logic [MEM_AW-1:0]   r_memAddr;
    logic [31:0]         r_memWdata;

    logic                w_awHs;
    logic                w_wHs;
    logic                w_haveAw;
    logic                w_haveW;
    logic [ID_W-1:0]     w_awid;
    logic [MEM_AW+1:0]   w_awaddr;
    logic [7:0]          w_awlen;
    logic [2:0]          w_awsize;
    logic [ID_W-1:0]     w_wid;
    logic [31:0]         w_wdata;
    logic [3:0]          w_wstrb;
    logic                w_wlast;
    logic                w_aligned;
    logic                w_legal;
    logic                w_unused;

    assign awready   = r_awready;
    assign wready    = r_wready;
    assign bvalid    = r_bvalid;
    assign bid       = r_bid;
    assign bresp     = r_bresp;
    assign mem_en    = r_memEn;
    assign mem_we    = r_memWe;
    assign mem_addr  = r_memAddr;
    assign mem_wdata = r_memWdata;

    assign w_awHs   = awvalid & r_awready;
    assign w_wHs    = wvalid & r_wready;
    assign w_haveAw = r_awCap | w_awHs;
    assign w_haveW  = r_wCap | w_wHs;

    // Decide on the captured value if one exists, otherwise on the value being
    // accepted this cycle, so a same-cycle AW/W pair is judged without delay.
    assign w_awid   = r_awCap ? r_awid   : awid;
    assign w_awaddr = r_awCap ? r_awaddr : awaddr[MEM_AW+1:0];
    assign w_awlen  = r_awCap ? r_awlen  : awlen;
    assign w_awsize = r_awCap ? r_awsize : awsize;
    assign w_wid    = r_wCap  ? r_wid    : wid;
    assign w_wdata  = r_wCap  ? r_wdata  : wdata;
    assign w_wstrb  = r_wCap  ? r_wstrb  : wstrb;
    assign w_wlast  = r_wCap  ? r_wlast  : wlast;

`ifdef AXI_WR_ALIGN_CHECK_EN
    assign w_aligned = isAligned(w_awaddr[1:0], w_awsize);
`else
    assign w_aligned = 1'b1;
`endif

    assign w_legal = (w_awlen == 8'd0) & w_wlast & (w_awsize <= 3'd2) &
                     (w_wid == w_awid) & w_aligned;

    // Burst type, address bits beyond the memory and (without the alignment
    // check) the byte offset carry no meaning for this slave.
    assign w_unused = ^{awburst, awaddr[31:MEM_AW+2], w_awaddr[1:0]};

    // Main FSM: capture AW/W in IDLE, then one of WRITE / DRAIN / RESP.
    // Ready signals are registered, so they rise on the first edge after reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_awCap    <= 1'b0;
            r_wCap     <= 1'b0;
            r_awid     <= '0;
            r_awaddr   <= '0;
            r_awlen    <= '0;
            r_awsize   <= '0;
            r_wid      <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_wlast    <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bid      <= '0;
            r_bresp    <= RESP_OKAY;
            r_memEn    <= 1'b0;
            r_memWe    <= '0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_awHs) begin
                        r_awCap  <= 1'b1;
                        r_awid   <= awid;
                        r_awaddr <= awaddr[MEM_AW+1:0];
                        r_awlen  <= awlen;
                        r_awsize <= awsize;
                    end
                    if (w_wHs) begin
                        r_wCap  <= 1'b1;
                        r_wid   <= wid;
                        r_wdata <= wdata;
                        r_wstrb <= wstrb;
                        r_wlast <= wlast;
                    end
                    if (w_haveAw && w_haveW) begin
                        r_awready <= 1'b0;
                        if (w_legal) begin
                            r_state    <= ST_WRITE;
                            r_wready   <= 1'b0;
                            r_memEn    <= 1'b1;
                            r_memWe    <= w_wstrb;
                            r_memAddr  <= w_awaddr[MEM_AW+1:2];
                            r_memWdata <= w_wdata;
                        end else if ((w_awlen != 8'd0) && !w_wlast) begin
                            r_state  <= ST_DRAIN;
                            r_wready <= 1'b1;
                        end else begin
                            r_state  <= ST_RESP;
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bid    <= w_awid;
                            r_bresp  <= RESP_SLVERR;
                        end
                    end else begin
                        r_awready <= ~w_haveAw;
                        r_wready  <= ~w_haveW;
                    end
                end

                ST_DRAIN: begin
                    if (wvalid && wlast) begin
                        r_state  <= ST_RESP;
                        r_wready <= 1'b0;
                        r_bvalid <= 1'b1;
                        r_bid    <= r_awid;
                        r_bresp  <= RESP_SLVERR;
                    end
                end

                ST_WRITE: begin
                    r_state  <= ST_RESP;
                    r_memEn  <= 1'b0;
                    r_memWe  <= '0;
                    r_bvalid <= 1'b1;
                    r_bid    <= r_awid;
                    r_bresp  <= RESP_OKAY;
                end

                ST_RESP: begin
                    if (bready) begin
                        r_state   <= ST_IDLE;
                        r_bvalid  <= 1'b0;
                        r_awCap   <= 1'b0;
                        r_wCap    <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                    end
                end

                default: begin
                    r_state   <= ST_IDLE;
                    r_awCap   <= 1'b0;
                    r_wCap    <= 1'b0;
                    r_awready <= 1'b1;
                    r_wready  <= 1'b1;
                    r_bvalid  <= 1'b0;
                    r_memEn   <= 1'b0;
                    r_memWe   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_wr_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_wr_slave
// Directed self-checking bench for axi_wr_slave (MEM_AW = 10).
// Inputs change 1 time unit after each rising edge; outputs are sampled there.
// Expectations for the misaligned scenario follow AXI_WR_ALIGN_CHECK_EN.
// ---------------------------------------------------------------------------
module tb_axi_wr_slave;

    logic        clk;
    logic        resetn;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;

    int checks;
    int failures;
    int memWrites;
    int wBeats;

    axi_wr_slave #(.MEM_AW(10)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .awid      (awid),
        .awaddr    (awaddr),
        .awlen     (awlen),
        .awsize    (awsize),
        .awburst   (awburst),
        .awvalid   (awvalid),
        .awready   (awready),
        .wid       (wid),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wlast     (wlast),
        .wvalid    (wvalid),
        .wready    (wready),
        .bid       (bid),
        .bresp     (bresp),
        .bvalid    (bvalid),
        .bready    (bready),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count memory write cycles and accepted W beats as seen on the bus.
    always @(posedge clk) begin
        if (mem_en) memWrites++;
        if (wvalid && wready) wBeats++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
            $error("[TB] check %s observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic awv, input logic [3:0] aid, input logic [31:0] addr,
                                 input logic [7:0] len, input logic [2:0] size,
                                 input logic wv, input logic [3:0] wi, input logic [31:0] data,
                                 input logic [3:0] strb, input logic last);
        awvalid = awv;
        awid    = aid;
        awaddr  = addr;
        awlen   = len;
        awsize  = size;
        wvalid  = wv;
        wid     = wi;
        wdata   = data;
        wstrb   = strb;
        wlast   = last;
    endtask

    // Hold bready for one edge to retire the pending response.
    task automatic ackResponse;
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        memWrites = 0;
        wBeats    = 0;
        resetn    = 1'b1;
        bready    = 1'b0;
        awburst   = 2'b01;
        applyStimulus(1'b0, 4'h0, 32'h0, 8'd0, 3'd0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0);

        // Reset state.
        #2 resetn = 1'b0;
        #1;
        checkOutput("rst_bvalid", {31'd0, bvalid}, 32'd0);
        checkOutput("rst_bresp", {30'd0, bresp}, 32'd0);
        checkOutput("rst_bid", {28'd0, bid}, 32'd0);
        checkOutput("rst_mem_en", {31'd0, mem_en}, 32'd0);
        checkOutput("rst_mem_we", {28'd0, mem_we}, 32'd0);
        tick();
        tick();
        resetn = 1'b1;
        tick();
        checkOutput("rel_awready", {31'd0, awready}, 32'd1);
        checkOutput("rel_wready", {31'd0, wready}, 32'd1);

        // AW and W in the same cycle, legal word write.
        applyStimulus(1'b1, 4'h1, 32'h10, 8'd0, 3'd2, 1'b1, 4'h1, 32'hDEADBEEF, 4'hF, 1'b1);
        tick();
        applyStimulus(1'b0, 4'h0, 32'h0, 8'd0, 3'd0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0);
        checkOutput("s1_mem_en", {31'd0, mem_en}, 32'd1);
        checkOutput("s1_mem_we", {28'd0, mem_we}, 32'hF);
        checkOutput("s1_mem_addr", {22'd0, mem_addr}, 32'd4);
        checkOutput("s1_mem_wdata", mem_wdata, 32'hDEADBEEF);
        checkOutput("s1_awready_wr", {31'd0, awready}, 32'd0);
        checkOutput("s1_wready_wr", {31'd0, wready}, 32'd0);
        tick();
        checkOutput("s1_mem_en_off", {31'd0, mem_en}, 32'd0);
        checkOutput("s1_bvalid", {31'd0, bvalid}, 32'd1);
        checkOutput("s1_bid", {28'd0, bid}, 32'd1);
        checkOutput("s1_bresp", {30'd0, bresp}, 32'd0);
        ackResponse();
        checkOutput("s1_bvalid_done", {31'd0, bvalid}, 32'd0);
        checkOutput("s1_awready_idle", {31'd0, awready}, 32'd1);
        checkOutput("s1_wready_idle", {31'd0, wready}, 32'd1);

        // W three cycles ahead of AW, partial strobe.
        applyStimulus(1'b0, 4'h0, 32'h0, 8'd0, 3'd0, 1'b1, 4'h2, 32'h12345678, 4'h3, 1'b1);
        tick();
        applyStimulus(1'b0, 4'h0, 32'h0, 8'd0, 3'd0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0);
        checkOutput("s2_wready_drop", {31'd0, wready}, 32'd0);
        checkOutput("s2_awready_hold", {31'd0, awready}, 32'd1);
        tick();
        tick();
        checkOutput("s2_no_early_write", {31'd0, mem_en}, 32'd0);
        applyStimulus(1'b1, 4'h2, 32'h20, 8'd0, 3'd2, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0);
        tick();
        applyStimulus(1'b0, 4'h0, 32'h0, 8'd0, 3'd0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0);
        checkOutput("s2_mem_en", {31'd0, mem_en}, 32'd1);
        checkOutput("s2_mem_we", {28'd0, mem_we}, 32'h3);
        checkOutput("s2_mem_addr", {22'd0, mem_addr}, 32'd8);
        checkOutput("s2_mem_wdata", mem_wdata, 32'h12345678);
        tick();
        checkOutput("s2_bvalid", {31'd0, bvalid}, 32'd1);
        checkOutput("s2_bid", {28'd0, bid}, 32'd2);
        checkOutput("s2_bresp", {30'd0, bresp}, 32'd0);
        ackResponse();

        // Burst of 4 beats is drained and rejected; then bready held low.
        wBeats = 0;
        applyStimulus(1'b1, 4'h3, 32'h40, 8'd3, 3'd2, 1'b1, 4'h3, 32'h11111111, 4'hF, 1'b0);
        tick();
        awvalid = 1'b0;
        checkOutput("s3_drain_wready", {31'd0, wready}, 32'd1);
        checkOutput("s3_drain_awready", {31'd0, awready}, 32'd0);
        checkOutput("s3_drain_mem_we", {28'd0, mem_we}, 32'h0);
        wdata = 32'h22222222;
        tick();
        wdata = 32'h33333333;
        tick();
        checkOutput("s3_drain_mem_en", {31'd0, mem_en}, 32'd0);
        wdata = 32'h44444444;
        wlast = 1'b1;
        tick();
        applyStimulus(1'b0, 4'h0, 32'h0, 8'd0, 3'd0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0);
        checkOutput("s3_beats", wBeats, 32'd4);
        checkOutput("s3_wready_resp", {31'd0, wready}, 32'd0);
        checkOutput("s3_bvalid", {31'd0, bvalid}, 32'd1);
        checkOutput("s3_bid", {28'd0, bid}, 32'd3);
        checkOutput("s3_bresp", {30'd0, bresp}, 32'd2);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("s4_bvalid_hold", {31'd0, bvalid}, 32'd1);
            checkOutput("s4_bid_hold", {28'd0, bid}, 32'd3);
            checkOutput("s4_bresp_hold", {30'd0, bresp}, 32'd2);
            checkOutput("s4_awready_low", {31'd0, awready}, 32'd0);
            checkOutput("s4_mem_we_low", {28'd0, mem_we}, 32'h0);
        end
        ackResponse();
        checkOutput("s4_bvalid_done", {31'd0, bvalid}, 32'd0);
        checkOutput("s4_awready_idle", {31'd0, awready}, 32'd1);
        checkOutput("s4_wready_idle", {31'd0, wready}, 32'd1);

        // ID mismatch goes straight to SLVERR with the AW ID.
        applyStimulus(1'b1, 4'h6, 32'h30, 8'd0, 3'd2, 1'b1, 4'h7, 32'h0BADF00D, 4'hF, 1'b1);
        tick();
        applyStimulus(1'b0, 4'h0, 32'h0, 8'd0, 3'd0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0);
        checkOutput("idm_mem_en", {31'd0, mem_en}, 32'd0);
        checkOutput("idm_bvalid", {31'd0, bvalid}, 32'd1);
        checkOutput("idm_bid", {28'd0, bid}, 32'd6);
        checkOutput("idm_bresp", {30'd0, bresp}, 32'd2);
        ackResponse();

        // Upper address bits are ignored: 0xABCDE3F8 -> word 0xFE, byte write.
        applyStimulus(1'b1, 4'h5, 32'hABCDE3F8, 8'd0, 3'd0, 1'b1, 4'h5, 32'h000000A5, 4'h1, 1'b1);
        tick();
        applyStimulus(1'b0, 4'h0, 32'h0, 8'd0, 3'd0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0);
        checkOutput("hi_mem_en", {31'd0, mem_en}, 32'd1);
        checkOutput("hi_mem_addr", {22'd0, mem_addr}, 32'h0FE);
        checkOutput("hi_mem_we", {28'd0, mem_we}, 32'h1);
        tick();
        checkOutput("hi_bresp", {30'd0, bresp}, 32'd0);
        ackResponse();

        // Misaligned word access at 0x13.
        applyStimulus(1'b1, 4'h4, 32'h13, 8'd0, 3'd2, 1'b1, 4'h4, 32'hCAFEF00D, 4'hF, 1'b1);
        tick();
        applyStimulus(1'b0, 4'h0, 32'h0, 8'd0, 3'd0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0);
`ifdef AXI_WR_ALIGN_CHECK_EN
        checkOutput("mis_mem_en", {31'd0, mem_en}, 32'd0);
        checkOutput("mis_bvalid", {31'd0, bvalid}, 32'd1);
        checkOutput("mis_bresp", {30'd0, bresp}, 32'd2);
        tick();
        checkOutput("mis_bid", {28'd0, bid}, 32'd4);
        checkOutput("mis_bresp_hold", {30'd0, bresp}, 32'd2);
`else
        checkOutput("mis_mem_en", {31'd0, mem_en}, 32'd1);
        checkOutput("mis_mem_addr", {22'd0, mem_addr}, 32'd4);
        checkOutput("mis_mem_wdata", mem_wdata, 32'hCAFEF00D);
        tick();
        checkOutput("mis_bid", {28'd0, bid}, 32'd4);
        checkOutput("mis_bresp", {30'd0, bresp}, 32'd0);
`endif
        ackResponse();

        // Reset while in RESP abandons the response.
        applyStimulus(1'b1, 4'h9, 32'h100, 8'd0, 3'd2, 1'b1, 4'h9, 32'h55AA55AA, 4'hF, 1'b1);
        tick();
        applyStimulus(1'b0, 4'h0, 32'h0, 8'd0, 3'd0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0);
        checkOutput("rr_mem_en", {31'd0, mem_en}, 32'd1);
        tick();
        checkOutput("rr_bvalid_pre", {31'd0, bvalid}, 32'd1);
        resetn = 1'b0;
        #1;
        checkOutput("rr_bvalid_async", {31'd0, bvalid}, 32'd0);
        checkOutput("rr_bid_async", {28'd0, bid}, 32'd0);
        tick();
        resetn = 1'b1;
        bready = 1'b1;
        tick();
        checkOutput("rr_awready", {31'd0, awready}, 32'd1);
        checkOutput("rr_wready", {31'd0, wready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("rr_no_bvalid", {31'd0, bvalid}, 32'd0);
            checkOutput("rr_no_write", {31'd0, mem_en}, 32'd0);
        end
        bready = 1'b0;

`ifdef AXI_WR_ALIGN_CHECK_EN
        checkOutput("total_writes", memWrites, 32'd4);
`else
        checkOutput("total_writes", memWrites, 32'd5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
